stream_mux_rr: RTL and testbench

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

---
 rtl/stream_mux_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/stream_mux_rr.sv | 57 +++++
 tb/tb_stream_mux_rr.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared arbitration mode constants and width helper
package stream_mux_pkg;
    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    // Never returns less than 1, so a select bus always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) if ((1 << i) < n) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin / fixed-priority grant
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int MODE     = MODE_RR,
    localparam int SEL_W   = clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic [CHANNELS-1:0] gnt,
    output logic [SEL_W-1:0]    gnt_idx
);
    logic found;
    int   j;

    // Walk from ptr upward with wrap; fixed priority always walks from 0.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            j = (MODE == MODE_FIXED) ? k : (int'(ptr) + k) % CHANNELS;
            if (!found && |(req & (CHANNELS'(1) << j))) begin
                found   = 1'b1;
                gnt     = CHANNELS'(1) << j;
                gnt_idx = SEL_W'(j);
            end
        end
    end
endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: arbitrated N-to-1 stream mux with a registered output stage
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int MODE     = MODE_RR,
    localparam int SEL_W   = clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_sel
);
    logic [SEL_W-1:0]    ptr;
    logic [CHANNELS-1:0] gnt;
    logic [SEL_W-1:0]    gnt_idx;
    logic [WIDTH-1:0]    sel_data;
    logic                load_en;
    logic                xfer;

    rr_arbiter #(.CHANNELS(CHANNELS), .MODE(MODE)) u_arb (
        .req    (in_valid),
        .ptr    (ptr),
        .gnt    (gnt),
        .gnt_idx(gnt_idx)
    );

    always_comb begin
        load_en  = !out_valid || out_ready;
        xfer     = !rst && load_en && |in_valid;
        in_ready = xfer ? gnt : '0;
        sel_data = '0;
        for (int k = 0; k < CHANNELS; k++) if (gnt[k]) sel_data = in_data[k*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= gnt_idx;
            if (MODE == MODE_RR) ptr <= (gnt_idx == SEL_W'(CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed checks of round-robin, fixed-priority and 3-channel muxes
module tb_stream_mux_rr;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] a_data;
    logic [3:0]  a_valid, a_ready;
    logic [7:0]  a_odata;
    logic        a_ovalid, a_oready;
    logic [1:0]  a_sel;

    logic [31:0] f_data;
    logic [3:0]  f_valid, f_ready;
    logic [7:0]  f_odata;
    logic        f_ovalid, f_oready;
    logic [1:0]  f_sel;

    logic [23:0] t_data;
    logic [2:0]  t_valid, t_ready;
    logic [7:0]  t_odata;
    logic        t_ovalid, t_oready;
    logic [1:0]  t_sel;

    stream_mux_rr #(.WIDTH(8), .CHANNELS(4), .MODE(0)) u_rr4 (
        .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
        .out_data(a_odata), .out_valid(a_ovalid), .out_ready(a_oready), .out_sel(a_sel));

    stream_mux_rr #(.WIDTH(8), .CHANNELS(4), .MODE(1)) u_fx4 (
        .clk(clk), .rst(rst), .in_data(f_data), .in_valid(f_valid), .in_ready(f_ready),
        .out_data(f_odata), .out_valid(f_ovalid), .out_ready(f_oready), .out_sel(f_sel));

    stream_mux_rr #(.WIDTH(8), .CHANNELS(3), .MODE(0)) u_rr3 (
        .clk(clk), .rst(rst), .in_data(t_data), .in_valid(t_valid), .in_ready(t_ready),
        .out_data(t_odata), .out_valid(t_ovalid), .out_ready(t_oready), .out_sel(t_sel));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a_data = 32'h13121110; a_valid = 4'hf; a_oready = 1'b1;
        f_data = 32'h23222120; f_valid = 4'h0; f_oready = 1'b1;
        t_data = 24'h323130;   t_valid = 3'h0; t_oready = 1'b1;
        #1;
        chk("rst_in_ready", 32'(a_ready), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        a_valid = 4'h0;
        tick();
        chk("idle_valid", 32'(a_ovalid), 32'h0);
        chk("idle_data", 32'(a_odata), 32'h0);
        chk("idle_ready", 32'(a_ready), 32'h0);

        // all four valid: one word per cycle, sel 0,1,2,3,0,1
        a_valid = 4'hf;
        #1;
        chk("rr_ready0", 32'(a_ready), 32'h1);
        for (int n = 0; n < 6; n++) begin
            tick();
            chk($sformatf("rr_sel%0d", n), 32'(a_sel), 32'(n % 4));
            chk($sformatf("rr_data%0d", n), 32'(a_odata), 32'h10 + 32'(n % 4));
            chk($sformatf("rr_valid%0d", n), 32'(a_ovalid), 32'h1);
            chk($sformatf("rr_ready%0d", n + 1), 32'(a_ready), 32'(1 << ((n + 1) % 4)));
        end
        a_valid = 4'h0;
        tick();
        chk("rr_drain", 32'(a_ovalid), 32'h0);

        // backpressure holds the word and blocks all inputs
        a_data = 32'h131211a5; a_valid = 4'h1; a_oready = 1'b0;
        tick();
        chk("bp_load", 32'(a_odata), 32'ha5);
        a_data = 32'h1312115a;
        for (int n = 0; n < 3; n++) begin
            #1;
            chk($sformatf("bp_ready%0d", n), 32'(a_ready), 32'h0);
            tick();
            chk($sformatf("bp_hold%0d", n), 32'(a_odata), 32'ha5);
            chk($sformatf("bp_valid%0d", n), 32'(a_ovalid), 32'h1);
        end
        a_oready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(a_ready), 32'h1);
        tick();
        chk("bp_next", 32'(a_odata), 32'h5a);
        a_valid = 4'h0;
        tick();
        chk("bp_drain", 32'(a_ovalid), 32'h0);

        // reset mid-stream drops the held word and restarts from channel 0
        a_data = 32'h13121110; a_valid = 4'h4; a_oready = 1'b0;
        tick();
        chk("mr_sel", 32'(a_sel), 32'h2);
        a_valid = 4'hf; a_oready = 1'b1;
        rst = 1'b1;
        #1;
        chk("mr_rst_ready", 32'(a_ready), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("mr_valid", 32'(a_ovalid), 32'h0);
        chk("mr_data", 32'(a_odata), 32'h0);
        chk("mr_ready", 32'(a_ready), 32'h1);
        tick();
        chk("mr_sel0", 32'(a_sel), 32'h0);
        a_valid = 4'h0;

        // fixed priority: channel 1 always beats channel 3
        f_valid = 4'b1010;
        for (int n = 0; n < 4; n++) begin
            #1;
            chk($sformatf("fx_ready%0d", n), 32'(f_ready), 32'h2);
            tick();
            chk($sformatf("fx_sel%0d", n), 32'(f_sel), 32'h1);
            chk($sformatf("fx_data%0d", n), 32'(f_odata), 32'h21);
        end
        f_valid = 4'h0;

        // three channels: pointer wraps from 2 back to 0
        t_valid = 3'b100;
        #1;
        chk("w3_ready2", 32'(t_ready), 32'h4);
        tick();
        chk("w3_sel2", 32'(t_sel), 32'h2);
        t_valid = 3'b101;
        #1;
        chk("w3_ready0", 32'(t_ready), 32'h1);
        tick();
        chk("w3_sel0", 32'(t_sel), 32'h0);
        chk("w3_data0", 32'(t_odata), 32'h30);
        tick();
        chk("w3_sel2b", 32'(t_sel), 32'h2);
        t_valid = 3'h0;
        tick();
        chk("w3_drain", 32'(t_ovalid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
